// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath definitions: word width, shift-amount width and the signed word type.
package cordic_pkg;
    localparam int CORDIC_W = 32;
    localparam int AMT_W    = 5;

    typedef logic signed [CORDIC_W-1:0] word_t;
endpackage

// File: rtl/shift_if.sv
// Operand/result bundle for the shift unit. valid/ready semantics: in_valid qualifies A/amt
// at a rising edge; out_valid qualifies Y; there is no ready, so the unit never stalls.
interface shift_if
    import cordic_pkg::*;
#(
    parameter int N = CORDIC_W
);
    logic                   in_valid;
    logic signed [N-1:0]    A;
    logic [AMT_W-1:0]       amt;
    logic                   out_valid;
    logic signed [N-1:0]    Y;

    modport master (output in_valid, A, amt, input out_valid, Y);
    modport slave  (input in_valid, A, amt, output out_valid, Y);
endinterface

// File: rtl/shift_stage.sv
// One barrel-shifter stage: arithmetic right shift by SH when en is set, sign fill when SH >= N.
module shift_stage #(
    parameter int N  = 32,
    parameter int SH = 1
) (
    input  logic                en,
    input  logic signed [N-1:0] d,
    output logic signed [N-1:0] q
);
    generate
        if (SH >= N) begin : g_fill
            assign q = en ? {N{d[N-1]}} : d;
        end else begin : g_shift
            assign q = en ? (d >>> SH) : d;
        end
    endgenerate
endmodule

// File: rtl/shift.sv
// Registered arithmetic right shift (Y = A >>> amt), one-cycle latency.
// Define SHIFT_ROUND_EN for round-half-up instead of truncation.
module shift
    import cordic_pkg::*;
#(
    parameter int N = CORDIC_W
) (
    input  logic   clk,
    input  logic   rst,
    shift_if.slave bus
);
    logic signed [N-1:0] stage [0:AMT_W];
    logic signed [N-1:0] result;

    assign stage[0] = bus.A;

    generate
        for (genvar k = 0; k < AMT_W; k++) begin : g_stage
            shift_stage #(
                .N  (N),
                .SH (1 << k)
            ) u_stage (
                .en (bus.amt[k]),
                .d  (stage[k]),
                .q  (stage[k+1])
            );
        end
    endgenerate

`ifdef SHIFT_ROUND_EN
    // Round bit is the last bit shifted out, A[amt-1]; zero for amt = 0 or amt > N.
    logic [N-1:0] a_pre;
    logic         round_bit;

    always_comb begin
        a_pre     = bus.A >> (bus.amt - 5'd1);
        round_bit = 1'b0;
        if (bus.amt != '0 && int'(bus.amt) <= N) begin
            round_bit = a_pre[0];
        end
        result = stage[AMT_W] + $signed({{(N-1){1'b0}}, round_bit});
    end
`else
    assign result = stage[AMT_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Y         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.Y <= result;
            end
        end
    end
endmodule

// File: tb/tb_shift.sv
// Self-checking bench for shift (N = 32); define SHIFT_ROUND_EN to check the rounding build.
module tb_shift;
    localparam int W = 32;

    logic clk;
    logic rst;

    shift_if #(.N(W)) bus ();

    shift #(.N(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: floor division by 2^amt, with +2^(amt-1) bias in the rounding build.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input int sh);
        longint sa;
        longint d;
        longint q;
        sa = longint'($signed(a));
        d  = longint'(1) << sh;
`ifdef SHIFT_ROUND_EN
        if (sh > 0) sa = sa + (d >>> 1);
`endif
        q = sa / d;
        if (sa < 0 && q * d != sa) q = q - 1;
        return q[W-1:0];
    endfunction

    // driver tasks
    task automatic send(input logic [W-1:0] a, input logic [4:0] sh, input logic [W-1:0] exp);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.amt      = sh;
        @(posedge clk);
        if (!rst) begin
            exp_q.push_back(exp);
            last_exp = exp;
        end
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.A        = $urandom();
        bus.amt      = 5'($urandom_range(0, 31));
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every valid output pops one expected result
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 1'b1, 1'b0);
            else check("y", bus.Y, exp_q.pop_front());
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [4:0]   sh;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.amt      = '0;
        last_exp     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", bus.Y, '0);
        check("reset_valid", bus.out_valid, 1'b0);
        rst = 1'b0;
        idle();

`ifdef SHIFT_ROUND_EN
        send(32'd123, 5'd2, 32'd31);
`else
        send(32'd123, 5'd2, 32'd30);
`endif
        send(32'hFFFFFE38, 5'd3, 32'hFFFFFFC7);
        send(32'h80000000, 5'd31, 32'hFFFFFFFF);
`ifdef SHIFT_ROUND_EN
        send(32'h7FFFFFFF, 5'd31, 32'd1);
`else
        send(32'h7FFFFFFF, 5'd31, 32'd0);
`endif
        idle();

        for (int i = 0; i < 32; i++) begin
`ifdef SHIFT_ROUND_EN
            send(32'hFFFFFFFF, 5'(i), model(32'hFFFFFFFF, i));
`else
            send(32'hFFFFFFFF, 5'(i), 32'hFFFFFFFF);
`endif
        end
        idle();

        // back-to-back, then a bubble: valid drops and Y holds
        for (int i = 0; i < 4; i++) begin
            a  = 32'h1234_5678 * (i + 1) ^ 32'hA5A5_0000;
            sh = 5'(3 * i + 1);
            send(a, sh, model(a, int'(sh)));
        end
        idle();
        check("idle_valid", bus.out_valid, 1'b0);
        check("idle_hold", bus.Y, last_exp);
        idle();
        check("idle_hold2", bus.Y, last_exp);

        // reset wins over a simultaneous valid input
        rst = 1'b1;
        send(32'd100, 5'd1, 32'd50);
        check("rst_mid_y", bus.Y, '0);
        check("rst_mid_valid", bus.out_valid, 1'b0);
        rst = 1'b0;
        send(32'd77, 5'd1, model(32'd77, 1));
        idle();

        for (int i = 0; i < 60; i++) begin
            a  = $urandom();
            sh = 5'($urandom_range(0, 31));
            send(a, sh, model(a, int'(sh)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        repeat (3) idle();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
